// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU control unit: state encoding, memory
// commands, opcode/op codes, write-back selects and the control output bundle.
package cpu_pkg;

    typedef enum logic [4:0] {
        S_RST       = 5'd0,
        S_IF1       = 5'd1,
        S_IF2       = 5'd2,
        S_UPDATE_PC = 5'd3,
        S_DECODE    = 5'd4,
        S_WRITE_IMM = 5'd5,
        S_GET_A     = 5'd6,
        S_GET_B     = 5'd7,
        S_EXEC      = 5'd8,
        S_WRITE_REG = 5'd9,
        S_MEM_ADDR  = 5'd10,
        S_LOAD_ADDR = 5'd11,
        S_LDR_RD    = 5'd12,
        S_LDR_WB    = 5'd13,
        S_STR_GETB  = 5'd14,
        S_STR_PASS  = 5'd15,
        S_STR_WR    = 5'd16,
        S_HALT      = 5'd17
    } state_t;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_MEM  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;

    localparam logic [1:0] ALU_ADD = 2'b00;

    localparam logic [1:0] VSEL_DP    = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] op;
        logic [2:0] rn;
        logic [2:0] rd;
        logic [1:0] shift;
        logic [2:0] rm;
    } fields_t;

    typedef struct packed {
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       addr_sel;
        logic       load_addr;
        logic [1:0] mem_cmd;
        logic [1:0] vsel;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] alu_op;
        logic       halted;
    } ctrl_t;

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/cpu_control_if.sv
// Control bus between the CPU control FSM (master) and the datapath/memory
// side (slave): instruction in, strobes and immediates out.
interface cpu_control_if;
    logic [15:0] instr;
    logic        load_ir;
    logic        load_pc;
    logic        reset_pc;
    logic        addr_sel;
    logic        load_addr;
    logic [1:0]  mem_cmd;
    logic [1:0]  vsel;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
    logic        halted;

    modport master (
        input  instr,
        output load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, vsel,
               readnum, writenum, write, loada, loadb, loadc, loads, asel,
               bsel, shift, ALUop, sximm5, sximm8, halted
    );

    modport slave (
        output instr,
        input  load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, vsel,
               readnum, writenum, write, loada, loadb, loadc, loads, asel,
               bsel, shift, ALUop, sximm5, sximm8, halted
    );
endinterface

// File: rtl/cpu_control_instr_dec.sv
// Combinational instruction decoder: splits the instruction register into its
// fields and produces the sign-extended 5- and 8-bit immediates.
module instr_dec
    import cpu_pkg::*;
(
    input  logic [15:0] instr,
    output fields_t     fields,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8
);

    // Field extraction and sign extension straight from the instruction bits.
    always_comb begin
        fields.opcode = instr[15:13];
        fields.op     = instr[12:11];
        fields.rn     = instr[10:8];
        fields.rd     = instr[7:5];
        fields.shift  = instr[4:3];
        fields.rm     = instr[2:0];
        sximm5        = sext5(instr[4:0]);
        sximm8        = sext8(instr[7:0]);
    end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle CPU control FSM: fetch, decode and execute sequencing with all
// control strobes registered alongside the state.
module cpu_control
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    cpu_control_if.master bus
);

    fields_t     fld_s;
    logic [15:0] sximm5_s;
    logic [15:0] sximm8_s;
    state_t      state_r;
    state_t      nxt_s;
    ctrl_t       ctrl_r;

    instr_dec u_dec (
        .instr  (bus.instr),
        .fields (fld_s),
        .sximm5 (sximm5_s),
        .sximm8 (sximm8_s)
    );

    // Outputs are computed for the state being entered, so the registered copy
    // always matches the current state; instr is stable from UPDATE_PC onward.
    function automatic ctrl_t ctrl_for(input state_t s, input fields_t f);
        ctrl_t c;
        c = '0;
        case (s)
            S_RST:       begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
            S_IF1:       begin c.addr_sel = 1'b1; c.mem_cmd = MREAD; end
            S_IF2:       begin c.addr_sel = 1'b1; c.mem_cmd = MREAD; c.load_ir = 1'b1; end
            S_UPDATE_PC: c.load_pc = 1'b1;
            S_DECODE:    c = '0;
            S_WRITE_IMM: begin c.vsel = VSEL_IMM; c.writenum = f.rn; c.write = 1'b1; end
            S_GET_A:     begin c.readnum = f.rn; c.loada = 1'b1; end
            S_GET_B:     begin c.readnum = f.rm; c.loadb = 1'b1; end
            S_EXEC: begin
                c.shift = f.shift;
                c.loadc = 1'b1;
                if (f.opcode == OPC_MOV) begin
                    c.asel   = 1'b1;
                    c.alu_op = ALU_ADD;
                end else begin
                    c.asel   = 1'b0;
                    c.alu_op = f.op;
                end
                c.loads = (f.opcode == OPC_ALU) && (f.op == OP_CMP);
            end
            S_WRITE_REG: begin c.vsel = VSEL_DP; c.writenum = f.rd; c.write = 1'b1; end
            S_MEM_ADDR:  begin c.bsel = 1'b1; c.alu_op = ALU_ADD; c.loadc = 1'b1; end
            S_LOAD_ADDR: c.load_addr = 1'b1;
            S_LDR_RD:    c.mem_cmd = MREAD;
            S_LDR_WB: begin
                c.mem_cmd  = MREAD;
                c.vsel     = VSEL_MDATA;
                c.writenum = f.rd;
                c.write    = 1'b1;
            end
            S_STR_GETB:  begin c.readnum = f.rd; c.loadb = 1'b1; end
            S_STR_PASS:  begin c.asel = 1'b1; c.alu_op = ALU_ADD; c.loadc = 1'b1; end
            S_STR_WR:    c.mem_cmd = MWRITE;
            S_HALT:      c.halted = 1'b1;
            default:     c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection; DECODE dispatches on {opcode, op}.
    always_comb begin
        nxt_s = state_r;
        case (state_r)
            S_RST:       nxt_s = S_IF1;
            S_IF1:       nxt_s = S_IF2;
            S_IF2:       nxt_s = S_UPDATE_PC;
            S_UPDATE_PC: nxt_s = S_DECODE;
            S_DECODE: begin
                if ((fld_s.opcode == OPC_MOV) && (fld_s.op == OP_MOVI)) begin
                    nxt_s = S_WRITE_IMM;
                end else if ((fld_s.opcode == OPC_MOV) && (fld_s.op == OP_MOVR)) begin
                    nxt_s = S_GET_B;
                end else if (fld_s.opcode == OPC_ALU) begin
                    nxt_s = S_GET_A;
                end else if (((fld_s.opcode == OPC_LDR) || (fld_s.opcode == OPC_STR))
                             && (fld_s.op == OP_MEM)) begin
                    nxt_s = S_GET_A;
                end else if (fld_s.opcode == OPC_HALT) begin
                    nxt_s = S_HALT;
                end else begin
                    nxt_s = S_IF1;
                end
            end
            S_WRITE_IMM: nxt_s = S_IF1;
            S_GET_A: begin
                if (fld_s.opcode == OPC_ALU) begin
                    nxt_s = S_GET_B;
                end else begin
                    nxt_s = S_MEM_ADDR;
                end
            end
            S_GET_B:     nxt_s = S_EXEC;
            S_EXEC: begin
                if ((fld_s.opcode == OPC_ALU) && (fld_s.op == OP_CMP)) begin
                    nxt_s = S_IF1;
                end else begin
                    nxt_s = S_WRITE_REG;
                end
            end
            S_WRITE_REG: nxt_s = S_IF1;
            S_MEM_ADDR:  nxt_s = S_LOAD_ADDR;
            S_LOAD_ADDR: begin
                if (fld_s.opcode == OPC_LDR) begin
                    nxt_s = S_LDR_RD;
                end else begin
                    nxt_s = S_STR_GETB;
                end
            end
            S_LDR_RD:    nxt_s = S_LDR_WB;
            S_LDR_WB:    nxt_s = S_IF1;
            S_STR_GETB:  nxt_s = S_STR_PASS;
            S_STR_PASS:  nxt_s = S_STR_WR;
            S_STR_WR:    nxt_s = S_IF1;
            S_HALT:      nxt_s = S_HALT;
            default:     nxt_s = S_RST;
        endcase
    end

    // State and control outputs; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_RST;
            ctrl_r  <= ctrl_for(S_RST, fld_s);
        end else begin
            state_r <= nxt_s;
            ctrl_r  <= ctrl_for(nxt_s, fld_s);
        end
    end

    assign bus.load_ir   = ctrl_r.load_ir;
    assign bus.load_pc   = ctrl_r.load_pc;
    assign bus.reset_pc  = ctrl_r.reset_pc;
    assign bus.addr_sel  = ctrl_r.addr_sel;
    assign bus.load_addr = ctrl_r.load_addr;
    assign bus.mem_cmd   = ctrl_r.mem_cmd;
    assign bus.vsel      = ctrl_r.vsel;
    assign bus.readnum   = ctrl_r.readnum;
    assign bus.writenum  = ctrl_r.writenum;
    assign bus.write     = ctrl_r.write;
    assign bus.loada     = ctrl_r.loada;
    assign bus.loadb     = ctrl_r.loadb;
    assign bus.loadc     = ctrl_r.loadc;
    assign bus.loads     = ctrl_r.loads;
    assign bus.asel      = ctrl_r.asel;
    assign bus.bsel      = ctrl_r.bsel;
    assign bus.shift     = ctrl_r.shift;
    assign bus.ALUop     = ctrl_r.alu_op;
    assign bus.halted    = ctrl_r.halted;
    assign bus.sximm5    = sximm5_s;
    assign bus.sximm8    = sximm8_s;

endmodule

// File: tb/tb_cpu_control.sv
// Bench for cpu_control: directed vector table, reset/HALT sequences and a
// randomized instruction stream checked against a per-instruction-class model.
module tb_cpu_control;

    typedef struct packed {
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       addr_sel;
        logic       load_addr;
        logic [1:0] mem_cmd;
        logic [1:0] vsel;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic       halted;
    } ov_t;

    typedef struct {
        logic [15:0] ins;
        int          cyc;
        ov_t         e;
        logic [15:0] sx5;
        logic [15:0] sx8;
    } vec_t;

    localparam int C_NOP = 0, C_MOVI = 1, C_MOVR = 2, C_ALU = 3, C_CMP = 4,
                   C_LDR = 5, C_STR = 6, C_HALT = 7;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t tbl[$];

    cpu_control_if bus ();

    cpu_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic ov_t sample_dut();
        ov_t o;
        o.load_ir = bus.load_ir;   o.load_pc = bus.load_pc;   o.reset_pc = bus.reset_pc;
        o.addr_sel = bus.addr_sel; o.load_addr = bus.load_addr;
        o.mem_cmd = bus.mem_cmd;   o.vsel = bus.vsel;
        o.readnum = bus.readnum;   o.writenum = bus.writenum; o.write = bus.write;
        o.loada = bus.loada;       o.loadb = bus.loadb;       o.loadc = bus.loadc;
        o.loads = bus.loads;       o.asel = bus.asel;         o.bsel = bus.bsel;
        o.shift = bus.shift;       o.aluop = bus.ALUop;       o.halted = bus.halted;
        return o;
    endfunction

    function automatic int iclass(input logic [15:0] ins);
        int opc, op;
        opc = int'(ins[15:13]);
        op  = int'(ins[12:11]);
        if (opc == 6 && op == 2) return C_MOVI;
        if (opc == 6 && op == 0) return C_MOVR;
        if (opc == 5) return (op == 1) ? C_CMP : C_ALU;
        if (opc == 3 && op == 0) return C_LDR;
        if (opc == 4 && op == 0) return C_STR;
        if (opc == 7) return C_HALT;
        return C_NOP;
    endfunction

    // Cycles from one IF1 to the next, per instruction class.
    function automatic int ilen(input logic [15:0] ins);
        case (iclass(ins))
            C_MOVI: return 5;
            C_MOVR: return 7;
            C_CMP:  return 7;
            C_ALU:  return 8;
            C_LDR:  return 9;
            C_STR:  return 10;
            C_HALT: return 1 << 30;
            default: return 4;
        endcase
    endfunction

    function automatic ov_t rst_vec();
        ov_t o;
        o = '0;
        o.reset_pc = 1'b1;
        o.load_pc = 1'b1;
        return o;
    endfunction

    // Expected outputs k cycles after the IF1 of instruction ins.
    function automatic ov_t model(input logic [15:0] ins, input int k);
        ov_t o;
        int  cls, j;
        o = '0;
        cls = iclass(ins);
        j = k - 4;
        if (k == 0) begin
            o.addr_sel = 1'b1; o.mem_cmd = 2'b01;
        end else if (k == 1) begin
            o.addr_sel = 1'b1; o.mem_cmd = 2'b01; o.load_ir = 1'b1;
        end else if (k == 2) begin
            o.load_pc = 1'b1;
        end else if (k >= 4) begin
            case (cls)
                C_MOVI: begin o.vsel = 2'b10; o.writenum = ins[10:8]; o.write = 1'b1; end
                C_MOVR: begin
                    if (j == 0) begin o.readnum = ins[2:0]; o.loadb = 1'b1; end
                    if (j == 1) begin o.shift = ins[4:3]; o.loadc = 1'b1; o.asel = 1'b1; end
                    if (j == 2) begin o.writenum = ins[7:5]; o.write = 1'b1; end
                end
                C_ALU, C_CMP: begin
                    if (j == 0) begin o.readnum = ins[10:8]; o.loada = 1'b1; end
                    if (j == 1) begin o.readnum = ins[2:0]; o.loadb = 1'b1; end
                    if (j == 2) begin
                        o.shift = ins[4:3]; o.loadc = 1'b1; o.aluop = ins[12:11];
                        o.loads = (cls == C_CMP);
                    end
                    if (j == 3) begin o.writenum = ins[7:5]; o.write = 1'b1; end
                end
                C_LDR, C_STR: begin
                    if (j == 0) begin o.readnum = ins[10:8]; o.loada = 1'b1; end
                    if (j == 1) begin o.bsel = 1'b1; o.loadc = 1'b1; end
                    if (j == 2) o.load_addr = 1'b1;
                    if (cls == C_LDR && j == 3) o.mem_cmd = 2'b01;
                    if (cls == C_LDR && j == 4) begin
                        o.mem_cmd = 2'b01; o.vsel = 2'b11; o.writenum = ins[7:5]; o.write = 1'b1;
                    end
                    if (cls == C_STR && j == 3) begin o.readnum = ins[7:5]; o.loadb = 1'b1; end
                    if (cls == C_STR && j == 4) begin o.asel = 1'b1; o.loadc = 1'b1; end
                    if (cls == C_STR && j == 5) o.mem_cmd = 2'b10;
                end
                C_HALT: o.halted = 1'b1;
                default: o = '0;
            endcase
        end
        return o;
    endfunction

    function automatic logic [15:0] sext(input int v, input int bits);
        int t;
        t = v;
        if (t >= (1 << (bits - 1))) t = t - (1 << bits);
        return 16'(t);
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [15:0] v;
        int sel;
        v = 16'($urandom);
        sel = $urandom_range(0, 7);
        case (sel)
            0: v[15:11] = 5'b11010;
            1: v[15:11] = 5'b11000;
            2, 3: v[15:13] = 3'b101;
            4: v[15:11] = 5'b01100;
            5: v[15:11] = 5'b10000;
            default: if (v[15:13] == 3'b111) v[15:13] = 3'b010;
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input ov_t got, input ov_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic add(input logic [15:0] ins, input int cyc, input ov_t e,
                       input logic [15:0] sx5, input logic [15:0] sx8);
        vec_t v;
        v.ins = ins; v.cyc = cyc; v.e = e; v.sx5 = sx5; v.sx8 = sx8;
        tbl.push_back(v);
    endtask

    // Leaves the DUT in RST at a falling edge, with reset released.
    task automatic do_reset(input logic [15:0] ins);
        reset = 1'b1;
        bus.instr = ins;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        ov_t e;
        logic [15:0] cur;
        int k, halted_cnt;
        logic in_rst;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.instr = 16'h0000;

        e = rst_vec();                                   add(16'hD007, 0, e, 16'h0007, 16'h0007);
        e = '0; e.addr_sel = 1'b1; e.mem_cmd = 2'b01;    add(16'hD007, 1, e, 16'h0007, 16'h0007);
        e.load_ir = 1'b1;                                add(16'hD007, 2, e, 16'h0007, 16'h0007);
        e = '0; e.vsel = 2'b10; e.write = 1'b1;          add(16'hD007, 5, e, 16'h0007, 16'h0007);
        e.writenum = 3'd1;                               add(16'hD1FE, 5, e, 16'hFFFE, 16'hFFFE);
        e = '0; e.readnum = 3'd1; e.loada = 1'b1;        add(16'hA148, 5, e, 16'h0008, 16'h0048);
        e = '0; e.readnum = 3'd0; e.loadb = 1'b1;        add(16'hA148, 6, e, 16'h0008, 16'h0048);
        e = '0; e.shift = 2'b01; e.loadc = 1'b1;         add(16'hA148, 7, e, 16'h0008, 16'h0048);
        e = '0; e.writenum = 3'd2; e.write = 1'b1;       add(16'hA148, 8, e, 16'h0008, 16'h0048);
        e = '0; e.addr_sel = 1'b1; e.mem_cmd = 2'b01;    add(16'hA148, 9, e, 16'h0008, 16'h0048);
        e = '0; e.aluop = 2'b01; e.loads = 1'b1; e.loadc = 1'b1;
                                                         add(16'hA801, 7, e, 16'h0001, 16'h0001);
        e = '0; e.addr_sel = 1'b1; e.mem_cmd = 2'b01;    add(16'hA801, 8, e, 16'h0001, 16'h0001);
        e = '0; e.bsel = 1'b1; e.loadc = 1'b1;           add(16'h6064, 6, e, 16'h0004, 16'h0064);
        e = '0; e.load_addr = 1'b1;                      add(16'h6064, 7, e, 16'h0004, 16'h0064);
        e = '0; e.mem_cmd = 2'b01;                       add(16'h6064, 8, e, 16'h0004, 16'h0064);
        e.vsel = 2'b11; e.writenum = 3'd3; e.write = 1'b1;
                                                         add(16'h6064, 9, e, 16'h0004, 16'h0064);
        e = '0; e.readnum = 3'd3; e.loadb = 1'b1;        add(16'h807F, 8, e, 16'hFFFF, 16'h007F);
        e = '0; e.asel = 1'b1; e.loadc = 1'b1;           add(16'h807F, 9, e, 16'hFFFF, 16'h007F);
        e = '0; e.mem_cmd = 2'b10;                       add(16'h807F, 10, e, 16'hFFFF, 16'h007F);
        e = '0; e.addr_sel = 1'b1; e.mem_cmd = 2'b01;    add(16'h807F, 11, e, 16'hFFFF, 16'h007F);

        foreach (tbl[i]) begin
            do_reset(tbl[i].ins);
            ticks(tbl[i].cyc);
            chk($sformatf("vec%0d_%h_c%0d", i, tbl[i].ins, tbl[i].cyc), sample_dut(), tbl[i].e);
            chk16($sformatf("vec%0d_sximm5", i), bus.sximm5, tbl[i].sx5);
            chk16($sformatf("vec%0d_sximm8", i), bus.sximm8, tbl[i].sx8);
        end

        // HALT holds until reset, then a fresh fetch begins.
        do_reset(16'hE000);
        ticks(5);
        chk("halt_enter", sample_dut(), model(16'hE000, 4));
        halted_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.halted === 1'b1 && bus.write === 1'b0) halted_cnt++;
        end
        checks++;
        if (halted_cnt != 25) begin
            errors++;
            $display("FAIL halt_hold got=%0d expected=25", halted_cnt);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("halt_reset_rst", sample_dut(), rst_vec());
        @(negedge clk);
        chk("halt_reset_if1", sample_dut(), model(16'hE000, 0));

        // Reset mid-instruction (EXEC) abandons the write-back.
        do_reset(16'hA148);
        ticks(7);
        chk("exec_before_reset", sample_dut(), model(16'hA148, 6));
        reset = 1'b1;
        @(negedge clk);
        chk("exec_reset_rst", sample_dut(), rst_vec());
        @(negedge clk);
        chk("exec_reset_held", sample_dut(), rst_vec());
        reset = 1'b0;
        @(negedge clk);
        chk("exec_reset_if1", sample_dut(), model(16'hA148, 0));
        @(negedge clk);
        chk("exec_reset_if2", sample_dut(), model(16'hA148, 1));

        // Random instruction stream with occasional reset pulses.
        do_reset(rand_instr());
        cur = bus.instr;
        k = 0;
        in_rst = 1'b1;
        for (int n = 0; n < 3000 && errors < 20; n++) begin
            chk($sformatf("rand%0d_%h_k%0d", n, cur, k), sample_dut(),
                in_rst ? rst_vec() : model(cur, k));
            chk16("rand_sximm5", bus.sximm5, sext(int'(bus.instr[4:0]), 5));
            chk16("rand_sximm8", bus.sximm8, sext(int'(bus.instr[7:0]), 8));
            if (in_rst) begin
                k = 0;
            end else begin
                if (k == 1) begin
                    bus.instr = rand_instr();
                    cur = bus.instr;
                end
                k = (k + 1 == ilen(cur)) ? 0 : k + 1;
            end
            reset = ($urandom_range(0, 60) == 0);
            in_rst = reset;
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
